pc_sequencer: RTL

- Registered program-counter unit for the MIPS core. It merges PC register, PC+4, sign-extend/shift branch target, J-type target, jump-register and exception redirect into one sequential block.
- Parametrised in datapath width and reset/exception vectors.
- Adds stall, EPC capture and jump-register alignment checking.
- Sits between the control unit/ALU (condition inputs) and instruction memory (pc output).

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Registered program counter for the MIPS core: sequential, branch, jump, jr and exception redirect.
// Optional return-address stack is built when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             branch_ne,
    input  logic             zero,
    input  logic [15:0]      imm16,
    input  logic             jump,
    input  logic [25:0]      jindex,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc,
`ifdef PC_SEQ_RAS_EN
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic             ras_empty,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             redirect,
    output logic             misaligned,
    output logic [WIDTH-1:0] epc
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("pc_sequencer: WIDTH must be 32 or 64");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of 2 in 2..16");
    end

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             redirect_q, redirect_d;
    logic             misaligned_q, misaligned_d;

    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] jr_dest;
    logic             taken;

    assign pc_plus4  = pc_q + WIDTH'(4);
    // Word offset sign-extended and scaled to bytes; wraps modulo 2^WIDTH.
    assign br_target = pc_plus4 + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign j_target  = {pc_plus4[WIDTH-1:28], jindex, 2'b00};
    assign taken     = branch & (zero ^ branch_ne);

`ifdef PC_SEQ_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, top_idx;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Stack ops follow the request that actually wins arbitration this edge.
    assign do_push   = !exc && !stall && !jr && jump && ras_push;
    assign do_pop    = !exc && !stall && jr && ras_pop && (cnt_q != '0);
    assign top_idx   = wptr_q - PW'(1);
    assign jr_dest   = do_pop ? ras_q[top_idx] : jr_target;
    assign ras_empty = (cnt_q == '0);

    always_comb begin
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + PW'(1);
            if (cnt_q != (PW+1)'(RAS_DEPTH)) begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end else if (do_pop) begin
            wptr_d = top_idx;
            cnt_d  = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // A full stack overwrites its oldest slot because the write pointer simply wraps.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_q[wptr_q] <= pc_plus4;
        end
    end
`else
    assign jr_dest = jr_target;
`endif

    always_comb begin
        pc_d         = pc_plus4;
        epc_d        = epc_q;
        redirect_d   = 1'b0;
        misaligned_d = 1'b0;
        if (exc) begin
            pc_d       = EXC_VECTOR;
            epc_d      = pc_q;
            redirect_d = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (jr) begin
            redirect_d = 1'b1;
            if (jr_dest[1:0] != 2'b00) begin
                pc_d         = EXC_VECTOR;
                epc_d        = pc_q;
                misaligned_d = 1'b1;
            end else begin
                pc_d = jr_dest;
            end
        end else if (jump) begin
            pc_d       = j_target;
            redirect_d = 1'b1;
        end else if (taken) begin
            pc_d       = br_target;
            redirect_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign redirect   = redirect_q;
    assign misaligned = misaligned_q;

endmodule
